// File: rtl/psk_mixer.sv
// PSK baseband mixer: holds each symbol for SPS carrier samples, BPSK/QPSK with saturation; PSK_MIXER_DIFF_EN adds differential encoding.
// Latency: one cycle from sine_i/sine_q to mod_out; first valid sample two edges after the accepting edge.
// Backpressure: sym_ready only in LOAD or on the last sample of a symbol; a missing symbol there pulses underrun.
module psk_mixer #(
  parameter int DATA_W = 8,
  parameter int SPS    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mod_ena,
  input  logic                     mode,
  input  logic [1:0]               sym_data,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  input  logic signed [DATA_W-1:0] sine_i,
  input  logic signed [DATA_W-1:0] sine_q,
  output logic                     ena_mod,
  output logic signed [DATA_W-1:0] mod_out,
  output logic                     out_valid,
  output logic                     underrun
);

  localparam int CW = (SPS > 2) ? $clog2(SPS) : 1;
  localparam int SW = DATA_W + 2;
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = -SW'(2 ** (DATA_W - 1));

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      sym_q;
  logic            mode_q;
  logic [1:0]      sym_tx;
  logic            last, accept, starve, run_out;
  logic signed [SW-1:0]     i_ext, q_ext, i_t, q_t, sum, pre;
  logic signed [DATA_W-1:0] sat;

  assign last      = (cnt == CW'(SPS - 1));
  assign sym_ready = mod_ena & ((state == LOAD) | ((state == RUN) & last));
  assign accept    = sym_valid & sym_ready;
  assign run_out   = (state == RUN) & mod_ena & ~starve;

`ifdef PSK_MIXER_DIFF_EN
  logic [1:0] prev_bits;
  assign sym_tx = sym_data ^ prev_bits;

  always_ff @(posedge clk) begin
    if (rst || state_nxt == IDLE) prev_bits <= 2'b00;
    else if (accept)              prev_bits <= sym_tx;
  end
`else
  assign sym_tx = sym_data;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    starve    = 1'b0;
    if (!mod_ena) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
        LOAD: begin
          cnt_nxt = '0;
          if (sym_valid) state_nxt = RUN;
        end
        RUN: begin
          if (last) begin
            cnt_nxt = '0;
            if (!sym_valid) begin
              state_nxt = LOAD;
              starve    = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Signs are applied at DATA_W+2 bits so that negating the most negative sample cannot wrap.
  always_comb begin
    i_ext = SW'(sine_i);
    q_ext = SW'(sine_q);
    if (mode_q) begin
      i_t = sym_q[1] ? i_ext : -i_ext;
      q_t = sym_q[0] ? q_ext : -q_ext;
      sum = i_t + q_t;
      pre = sum >>> 1;
    end else begin
      i_t = sym_q[0] ? i_ext : -i_ext;
      q_t = '0;
      sum = i_t;
      pre = i_t;
    end
    if (pre > MAXV)      sat = MAXV[DATA_W-1:0];
    else if (pre < MINV) sat = MINV[DATA_W-1:0];
    else                 sat = pre[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sym_q     <= 2'b00;
      mode_q    <= 1'b0;
      ena_mod   <= 1'b0;
      mod_out   <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt == IDLE) begin
        sym_q  <= 2'b00;
        mode_q <= 1'b0;
      end else if (accept) begin
        sym_q  <= sym_tx;
        mode_q <= mode;
      end
      ena_mod   <= mod_ena;
      out_valid <= run_out;
      mod_out   <= run_out ? sat : '0;
      underrun  <= starve;
    end
  end

endmodule

// File: tb/tb_psk_mixer.sv
// Bench for psk_mixer (DATA_W=8, SPS=4): table of symbols streamed back-to-back into a sample scoreboard, plus starvation/abort sequences.
module tb_psk_mixer;
  localparam int DW  = 8;
  localparam int SPS = 4;

  logic                 clk = 1'b0;
  logic                 rst, mod_ena, mode, sym_valid;
  logic [1:0]           sym_data;
  logic                 sym_ready, ena_mod, out_valid, underrun;
  logic signed [DW-1:0] sine_i, sine_q, mod_out;

  psk_mixer #(.DATA_W(DW), .SPS(SPS)) dut (
    .clk(clk), .rst(rst), .mod_ena(mod_ena), .mode(mode),
    .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sine_i(sine_i), .sine_q(sine_q), .ena_mod(ena_mod),
    .mod_out(mod_out), .out_valid(out_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [1:0] sym;
    int         si;
    int         sq;
    int         ex;
  } vec_t;

  vec_t       vecs[10];
  int         exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         run_len = 0;
  int         max_run = 0;
  int         ucnt = 0;
  int         exp_u = 1;
  logic [1:0] prev_tx = 2'b00;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Present one symbol, wait (bounded) for the handshake, then drive the carrier for its samples.
  task automatic send(input logic m, input logic [1:0] s, input int si, input int sq,
                      input int ex, input int nsamp, input bit raw);
    logic [1:0] tx;
    int n;
    if (raw) begin
      sym_data = s;
      tx       = s ^ prev_tx;
    end else begin
      sym_data = s ^ prev_tx;
      tx       = s;
    end
    mode      = m;
    sym_valid = 1'b1;
    n = 0;
    while (!sym_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("handshake_ready", int'(sym_ready), 1);
    @(posedge clk); #1;
    sine_i    = DW'(si);
    sine_q    = DW'(sq);
    sym_valid = 1'b0;
`ifdef PSK_MIXER_DIFF_EN
    prev_tx = tx;
`endif
    for (int i = 0; i < nsamp; i++) exp_q.push_back(ex);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", int'(mod_out), 9999);
        end else begin
          chk("mod_out", int'(mod_out), exp_q.pop_front());
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (underrun) begin
        ucnt++;
        chk("underrun_out_valid", int'(out_valid), 0);
        chk("underrun_sym_ready", int'(sym_ready), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got 0 want 1");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b0, 2'b01,  100,    0,  100};
    vecs[1] = '{1'b0, 2'b00, -128,    0,  127};
    vecs[2] = '{1'b1, 2'b10,  100,   50,   25};
    vecs[3] = '{1'b1, 2'b00, -128, -128,  127};
    vecs[4] = '{1'b0, 2'b10,  100,    0, -100};
    vecs[5] = '{1'b1, 2'b11,  127,  127,  127};
    vecs[6] = '{1'b1, 2'b11, -128, -128, -128};
    vecs[7] = '{1'b1, 2'b01,  100,  -28,  -64};
    vecs[8] = '{1'b1, 2'b10,   -3,    2,   -3};
    vecs[9] = '{1'b0, 2'b01, -128,    0, -128};

    rst = 1'b1; mod_ena = 1'b1; mode = 1'b0; sym_valid = 1'b0;
    sym_data = 2'b00; sine_i = '0; sine_q = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mod_out",   int'(mod_out),   0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ena_mod",   int'(ena_mod),   0);
    chk("rst_sym_ready", int'(sym_ready), 0);
    chk("rst_underrun",  int'(underrun),  0);
    rst = 1'b0;

    // Back-to-back stream; the final symbol is starved so its last sample is not valid.
    for (int k = 0; k < 10; k++)
      send(vecs[k].m, vecs[k].sym, vecs[k].si, vecs[k].sq, vecs[k].ex,
           (k == 9) ? SPS - 1 : SPS, 1'b0);

    n = 0;
    while (!underrun && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("starve_underrun", int'(underrun), 1);
    chk("starve_out_valid", int'(out_valid), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("starve_pulse_single", int'(underrun), 0);
      chk("starve_ready_held",   int'(sym_ready), 1);
      chk("starve_no_output",    int'(out_valid), 0);
    end

    // Resupply, then abort with mod_ena low while counter = 2.
    send(1'b0, 2'b01, 77, 0, 77, 2, 1'b0);
    chk("resume_edge1_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("resume_edge2_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    mod_ena = 1'b0;
    @(posedge clk); #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_mod_out",   int'(mod_out),   0);
    chk("abort_ena_mod",   int'(ena_mod),   0);
    chk("abort_sym_ready", int'(sym_ready), 0);
    chk("abort_underrun",  int'(underrun),  0);
    prev_tx = 2'b00;

    // mod_ena drops exactly on the wrap cycle while a symbol is offered.
    mod_ena = 1'b1;
    @(posedge clk); #1;
    chk("reen_ena_mod", int'(ena_mod), 1);
    send(1'b1, 2'b11, 60, 40, 50, 3, 1'b0);
    sym_data = 2'b00; mode = 1'b0; sym_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wrap_ready", int'(sym_ready), 1);
    mod_ena = 1'b0;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    chk("wrap_underrun",  int'(underrun),  0);
    chk("wrap_out_valid", int'(out_valid), 0);
    chk("wrap_ena_mod",   int'(ena_mod),   0);
    prev_tx = 2'b00;
    mod_ena = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("load_no_output", int'(out_valid), 0);

`ifdef PSK_MIXER_DIFF_EN
    send(1'b0, 2'b01, 100, 0,  100, SPS,     1'b1);
    send(1'b0, 2'b01, 100, 0, -100, SPS,     1'b1);
    send(1'b0, 2'b00, 100, 0, -100, SPS - 1, 1'b1);
    exp_u = 2;
    n = 0;
    while (!underrun && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("diff_underrun", int'(underrun), 1);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained",  exp_q.size(), 0);
    chk("max_valid_run",  max_run, 10 * SPS - 1);
    chk("underrun_count", ucnt, exp_u);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/psk_mixer.md
# psk_mixer

Parametrised PSK baseband mixer for the TX chain, successor to the single-channel 8-bit BPSK mixer. Takes symbols through a valid/ready handshake, holds each for a fixed number of carrier samples, and multiplies them onto the in-phase (and, in QPSK mode, quadrature) carrier. It sits between the symbol source/framer and the DAC interface. Relative to the earlier mixer it adds:
- configurable sample width and samples-per-symbol
- QPSK mode
- saturating arithmetic
- underrun reporting

## Interface
Parameters:
- DATA_W, 8, carrier/output sample width (signed, two's complement), ≥4
- SPS, 16, carrier samples per symbol, ≥2

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- mod_ena  in  1  modulator enable
- mode  in  1  0 = BPSK, 1 = QPSK; latched with each symbol
- sym_data  in  2  symbol bits; BPSK uses bit 0 only
- sym_valid  in  1  symbol available
- sym_ready  out  1  block accepts symbol this cycle (combinational from state/counter)
- sine_i  in  DATA_W signed  in-phase carrier sample
- sine_q  in  DATA_W signed  quadrature carrier sample
- ena_mod  out  1  registered; high while modulator is active (LOAD or RUN)
- mod_out  out  DATA_W signed  registered modulated sample
- out_valid  out  1  registered; mod_out is valid
- underrun  out  1  registered one-cycle pulse on symbol starvation

## Operation
States:
- **IDLE**
  - Entry: after rst, or whenever mod_ena = 0.
  - sym_ready = 0; counter = 0.
  - Exit: mod_ena = 1 → LOAD.
- **LOAD**
  - sym_ready = 1.
  - Exit: on sym_valid & sym_ready, latch sym_data and mode, clear counter → RUN.
- **RUN**
  - Every cycle, register mod_out from the latched symbol and the current sine_i/sine_q; counter increments.
  - sym_ready = 1 only when counter = SPS-1.
  - At counter = SPS-1 with sym_valid: latch the new symbol, counter → 0, stay in RUN. Output is seamless and gap-free.
  - At counter = SPS-1 without sym_valid: → LOAD and pulse underrun.
- **mod_ena = 0 in any state** → IDLE on the next edge.
  - Latched symbol discarded.
  - A handshake cannot complete in that cycle, because sym_ready is forced 0 when mod_ena = 0.

Arithmetic (sign bit = 1 means +carrier, 0 means −carrier):
- **BPSK:** mod_out = ±sine_i.
  - Negation saturates: −(−2^(DATA_W−1)) → 2^(DATA_W−1)−1.
- **QPSK:** bit 1 selects the sign of I, bit 0 selects the sign of Q.
  - Sum computed at DATA_W+2 bits, arithmetic shift right 1, then saturate to DATA_W.

## Timing
- Reset values: mod_out = 0, out_valid = 0, ena_mod = 0, underrun = 0; state IDLE; counter 0; symbol register 0.
- Latency: one cycle from sine_i/sine_q sample to mod_out.
  - The first out_valid appears on the edge ending the first RUN cycle, i.e. 2 edges after the accepting edge.
- Outside RUN: mod_out = 0 and out_valid = 0, registered.
- ena_mod rises one edge after mod_ena rises, and falls one edge after it falls.
- Symbol accepted in RUN: the new symbol affects the sample registered on the edge following the accepting edge. Each symbol therefore yields exactly SPS valid samples.
- Underrun: pulse is asserted on the edge that enters LOAD.
  - out_valid drops that same edge.
  - Counter is held at 0 until the next symbol arrives.
- Simultaneous mod_ena drop and counter wrap: IDLE wins. No underrun pulse, no symbol accepted.
- rst overrides everything, including mid-symbol.

## Configuration
- PSK_MIXER_DIFF_EN
  - **Defined:** differential encoding. Each accepted symbol bit is XORed with the previously transmitted bit of the same position, and the result is used for sign selection.
    - The previous-bit register resets to 0 on rst and on entering IDLE.
    - It is not cleared by underrun.
  - **Undefined:** sym_data drives the signs directly, and the previous-bit register is absent.

## Test plan
- Reset check: assert rst with mod_ena = 1 → next edge mod_out = 0, out_valid = 0, ena_mod = 0, sym_ready = 0.
- BPSK: DATA_W = 8, SPS = 4, mode = 0. Send sym_data = 1 with sine_i = 100 → mod_out = 100 for 4 valid samples. Then sym_data = 0 with sine_i = −128 → mod_out = 127 (saturated).
- QPSK: sym = 2'b10 with I = 100, Q = 50 → mod_out = 25. Then sym = 2'b00 with I = −128, Q = −128 → mod_out = 127 (saturated).
- Back-to-back: hold sym_valid high for 5 symbols → sym_ready pulses every 4th RUN cycle; out_valid high for 20 consecutive cycles; no underrun.
- Starvation: withhold sym_valid after one symbol → single-cycle underrun pulse, out_valid low, sym_ready held high. Resupply → output resumes 2 edges after acceptance.
- Abort and differential:
  - Drop mod_ena at counter = 2 → IDLE next edge, mod_out = 0, with no underrun pulse.
  - With PSK_MIXER_DIFF_EN, BPSK input bits 1, 1, 0 → transmitted signs +, −, −.
